// File: rtl/vnarrow_pack_pkg.sv
// rtl/vnarrow_pack_pkg.sv - shared types for the narrowing-shift result packer
package vnarrow_pack_pkg;

  typedef logic [63:0] bus64_t;
  typedef logic [31:0] bus32_t;

  typedef enum logic [1:0] {
    VNP_EMPTY,
    VNP_HALF,
    VNP_FULL
  } vnp_state_t;

endpackage

// File: rtl/vnarrow_pack.sv
// rtl/vnarrow_pack.sv - packs two 32-bit narrow beats into one 64-bit vd word
// VNARROW_PACK_TAIL_AGNOSTIC_EN: tail fill is all-ones instead of old_vd_i[63:32].
module vnarrow_pack
  import vnarrow_pack_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [OUT_W/2-1:0] data_i,
  input  logic               last_i,
  input  logic [OUT_W-1:0]   old_vd_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [OUT_W-1:0]   data_o,
  output logic               tail_o
);

  localparam int HALF_W = OUT_W / 2;

  vnp_state_t        state_q, state_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              tail_q, tail_d;

  logic              accept;
  bus32_t            tail_fill;
  vnp_state_t        first_state;
  logic [OUT_W-1:0]  first_data;
  logic              unused_old_vd;

`ifdef VNARROW_PACK_TAIL_AGNOSTIC_EN
  assign tail_fill = '1;
`else
  assign tail_fill = old_vd_i[OUT_W-1:HALF_W];
`endif
  assign unused_old_vd = ^old_vd_i;

  assign ready_o = (state_q != VNP_FULL) || ready_i;
  assign accept  = valid_i && ready_o;
  assign valid_o = (state_q == VNP_FULL);
  assign data_o  = data_q;
  assign tail_o  = tail_q;

  // A beat arriving with nothing held becomes the low half; last_i closes the word early.
  assign first_state = last_i ? VNP_FULL : VNP_HALF;
  assign first_data  = {(last_i ? tail_fill : bus32_t'(0)), data_i};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tail_d  = tail_q;
    unique case (state_q)
      VNP_EMPTY: begin
        if (accept) begin
          state_d = first_state;
          data_d  = first_data;
          tail_d  = last_i;
        end
      end
      VNP_HALF: begin
        if (accept) begin
          state_d                 = VNP_FULL;
          data_d[OUT_W-1:HALF_W]  = data_i;
          tail_d                  = 1'b0;
        end
      end
      VNP_FULL: begin
        if (ready_i) begin
          if (accept) begin
            state_d = first_state;
            data_d  = first_data;
            tail_d  = last_i;
          end else begin
            state_d = VNP_EMPTY;
          end
        end
      end
      default: state_d = VNP_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= VNP_EMPTY;
      data_q  <= '0;
      tail_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= VNP_EMPTY;
      data_q  <= '0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_vnarrow_pack.sv
// tb/tb_vnarrow_pack.sv - randomized bench for vnarrow_pack against a word-queue model
// Expected tail fill follows VNARROW_PACK_TAIL_AGNOSTIC_EN.
module tb_vnarrow_pack;

  logic        clk = 1'b0;
  logic        rstn_i, flush_i, valid_i, ready_i, last_i;
  logic [31:0] data_i;
  logic [63:0] old_vd_i;
  logic        ready_o, valid_o, tail_o;
  logic [63:0] data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vnarrow_pack #(.OUT_W(64)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .old_vd_i(old_vd_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .tail_o  (tail_o)
  );

  // Model: completed words waiting for writeback as {tail, hi, lo}, plus a pending low half.
  logic [64:0] exp_q[$];
  bit          have_lo = 1'b0;
  logic [31:0] m_lo;
  int          stalls = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [63:0] ovd);
`ifdef VNARROW_PACK_TAIL_AGNOSTIC_EN
    return 32'hFFFF_FFFF;
`else
    return ovd[63:32];
`endif
  endfunction

  task automatic step(input bit v, input logic [31:0] d, input bit l,
                      input logic [63:0] o, input bit r, input bit f);
    bit m_ready, acc, drn;
    @(negedge clk);
    valid_i  = v;
    data_i   = d;
    last_i   = l;
    old_vd_i = o;
    ready_i  = r;
    flush_i  = f;
    #1;
    m_ready = (exp_q.size() == 0) || r;
    if (!ready_o) stalls++;
    check("ready_o", {64'd0, ready_o}, {64'd0, m_ready});
    check("valid_o", {64'd0, valid_o}, {64'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("word", {tail_o, data_o}, exp_q[0]);
    @(posedge clk);
    acc = v && m_ready;
    drn = (exp_q.size() != 0) && r;
    if (f) begin
      exp_q.delete();
      have_lo = 1'b0;
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        if (have_lo) begin
          exp_q.push_back({1'b0, d, m_lo});
          have_lo = 1'b0;
        end else if (l) begin
          exp_q.push_back({1'b1, fill(o), d});
        end else begin
          have_lo = 1'b1;
          m_lo    = d;
        end
      end
    end
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    last_i = 1'b0; data_i = '0; old_vd_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", {64'd0, valid_o}, 65'd0);
    check("rst_data", {1'b0, data_o}, 65'd0);
    check("rst_tail", {64'd0, tail_o}, 65'd0);
    check("rst_ready", {64'd0, ready_o}, 65'd1);
    rstn_i = 1'b1;

    // Two beats form one word
    step(1, 32'h1111_2222, 0, 64'h0, 1, 0);
    step(1, 32'h3333_4444, 1, 64'h0, 1, 0);
    #2;
    check("t1_word", {valid_o, tail_o, data_o[63:1], data_o[0]},
          {1'b1, 1'b0, 64'h3333_4444_1111_2222});

    // Single last beat takes tail fill
    step(0, 32'h0, 0, 64'h0, 1, 0);
    step(1, 32'hDEAD_BEEF, 1, 64'hAAAA_5555_0000_0000, 1, 0);
    #2;
`ifdef VNARROW_PACK_TAIL_AGNOSTIC_EN
    check("t2_tail_word", {tail_o, data_o}, {1'b1, 64'hFFFF_FFFF_DEAD_BEEF});
`else
    check("t2_tail_word", {tail_o, data_o}, {1'b1, 64'hAAAA_5555_DEAD_BEEF});
`endif

    // Continuous streaming without bubbles
    stalls = 0;
    for (int i = 0; i < 8; i++) step(1, 32'hC0DE_0000 + i, 0, 64'h0, 1, 0);
    check("t3_stalls", 65'(stalls), 65'd0);

    // Back-pressure, then drain and accept together
    for (int i = 0; i < 5; i++) step(1, 32'h5555_0000 + i, 0, 64'h0, 0, 0);
    step(1, 32'h7777_8888, 0, 64'h0, 1, 0);
    #2;
    check("t4_half_valid", {64'd0, valid_o}, 65'd0);
    check("t4_half_ready", {64'd0, ready_o}, 65'd1);

    // Flush discards the held low half
    step(1, 32'h9999_9999, 0, 64'h0, 0, 1);
    step(1, 32'h0000_0001, 0, 64'h0, 0, 0);
    step(1, 32'h0000_0002, 0, 64'h0, 0, 0);
    #2;
    check("t5_word", {tail_o, data_o}, {1'b0, 64'h0000_0002_0000_0001});

    // Asynchronous reset while a word is presented
    step(0, 32'h0, 0, 64'h0, 0, 0);
    @(negedge clk);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t6_valid", {64'd0, valid_o}, 65'd0);
    check("t6_data", {1'b0, data_o}, 65'd0);
    check("t6_tail", {64'd0, tail_o}, 65'd0);
    exp_q.delete();
    have_lo = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    step(0, 32'h0, 0, 64'h0, 0, 0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
           {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
